// File: rtl/reg_file_scoreboard_pkg.sv
// Register map constants and the register address type shared by the
// register-file scoreboard and its testbench.
package reg_file_scoreboard_pkg;
   localparam int REG_COUNT = 32;

   typedef logic [4:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = 5'd0;
   localparam reg_addr_t LO_REG   = 5'd30;
   localparam reg_addr_t HI_REG   = 5'd31;
endpackage

// File: rtl/reg_file_scoreboard_busy_counter.sv
// Pending-write counter for one register.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc      : one more write reserved this cycle
//   dec      : one write retired this cycle
//   clr      : drop every reservation (pipeline flush); wins over inc/dec
//   count    : current number of outstanding writes
//   full     : count has reached MAX_PEND
// The counter saturates at both ends: inc at MAX_PEND and dec at 0 both hold.
// The parent reports the dec-at-0 case as a protocol error.
module busy_counter #(
   parameter int CNT_W    = 3,
   parameter int MAX_PEND = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             full
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TOP = CNT_W'(MAX_PEND);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !dec) begin
         if (count_q != TOP) count_d = count_q + ONE;
      end else if (dec && !inc) begin
         if (count_q != '0) count_d = count_q - ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;
   assign full  = (count_q == TOP);
endmodule

// File: rtl/reg_file_scoreboard.sv
// MIPS register file with a per-register pending-write scoreboard.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   rd_addr/rd_data     : NUM_RD combinational read ports with write-through bypass
//   rd_busy             : per read port, register still has outstanding writes
//   iss_valid/iss_dst   : reserve one destination
//   iss_hilo            : reserve both LO (30) and HI (31)
//   iss_ready           : reservation can be accepted this cycle
//   wb_valid/wb_dst/wb_data : general writeback, retires one reservation
//   hilo_valid/lo_data/hi_data : LO/HI writeback, retires both reservations
//   flush               : clear every reservation at the next edge
//   err                 : sticky protocol error (wb/hilo collision or underflow)
module reg_file_scoreboard
   import reg_file_scoreboard_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_RD   = 2,
   parameter int CNT_W    = 3,
   parameter int MAX_PEND = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*5-1:0]      rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     iss_valid,
   input  logic [4:0]               iss_dst,
   input  logic                     iss_hilo,
   output logic                     iss_ready,
   input  logic                     wb_valid,
   input  logic [4:0]               wb_dst,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic                     hilo_valid,
   input  logic [DATA_W-1:0]        lo_data,
   input  logic [DATA_W-1:0]        hi_data,
   input  logic                     flush,
   output logic                     err
);
   logic [REG_COUNT-1:0][DATA_W-1:0] regs_q, regs_d;
   logic                             err_q, err_d;

   logic [REG_COUNT-1:0][CNT_W-1:0]  cnt;
   logic [REG_COUNT-1:0]             full;
   logic [REG_COUNT-1:0]             dec;
   logic [REG_COUNT-1:1]             inc;

   logic conflict, wb_ok, iss_acc, underflow;

   // A general writeback aimed at LO/HI while the dedicated port is active
   // is dropped entirely; the dedicated port owns those registers that cycle.
   assign conflict = wb_valid && hilo_valid && (wb_dst == LO_REG || wb_dst == HI_REG);
   assign wb_ok    = wb_valid && (wb_dst != ZERO_REG) && !conflict;

   always_comb begin
      dec = '0;
      for (int a = 1; a < REG_COUNT; a++) begin
         dec[a] = (wb_ok && wb_dst == reg_addr_t'(a)) ||
                  (hilo_valid && (reg_addr_t'(a) == LO_REG || reg_addr_t'(a) == HI_REG));
      end
   end

   // A full counter can still take a reservation if it retires one this cycle.
   always_comb begin
      iss_ready = 1'b1;
      if (iss_valid && full[iss_dst] && !dec[iss_dst]) iss_ready = 1'b0;
      if (iss_hilo && ((full[LO_REG] && !dec[LO_REG]) || (full[HI_REG] && !dec[HI_REG])))
         iss_ready = 1'b0;
   end

   assign iss_acc = iss_ready && !flush;

   always_comb begin
      inc = '0;
      for (int a = 1; a < REG_COUNT; a++) begin
         inc[a] = iss_acc &&
                  ((iss_valid && iss_dst == reg_addr_t'(a)) ||
                   (iss_hilo && (reg_addr_t'(a) == LO_REG || reg_addr_t'(a) == HI_REG)));
      end
   end

   always_comb begin
      underflow = 1'b0;
      for (int a = 1; a < REG_COUNT; a++) begin
         if (dec[a] && cnt[a] == '0) underflow = 1'b1;
      end
   end

   assign cnt[0]  = '0;
   assign full[0] = 1'b0;

   for (genvar g = 1; g < REG_COUNT; g++) begin : g_cnt
      busy_counter #(.CNT_W(CNT_W), .MAX_PEND(MAX_PEND)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (inc[g]),
         .dec   (dec[g]),
         .clr   (flush),
         .count (cnt[g]),
         .full  (full[g])
      );
   end

   always_comb begin
      regs_d = regs_q;
      if (wb_ok) regs_d[wb_dst] = wb_data;
      if (hilo_valid) begin
         regs_d[LO_REG] = lo_data;
         regs_d[HI_REG] = hi_data;
      end
      regs_d[ZERO_REG] = '0;
   end

   assign err_d = err_q || conflict || underflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '0;
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         err_q  <= err_d;
      end
   end

   assign err = err_q;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      reg_addr_t         a;
      logic [DATA_W-1:0] d;
      logic [CNT_W-1:0]  left;

      assign a = rd_addr[i*5 +: 5];

      // Bypass priority: hilo port over general writeback over storage.
      always_comb begin
         d = regs_q[a];
         if (wb_valid && wb_dst == a)       d = wb_data;
         if (hilo_valid && a == LO_REG)     d = lo_data;
         if (hilo_valid && a == HI_REG)     d = hi_data;
         if (a == ZERO_REG)                 d = '0;
      end

      // Busy reflects this cycle's retirement but not this cycle's issue.
      assign left       = cnt[a] - {{(CNT_W-1){1'b0}}, dec[a]};
      assign rd_busy[i] = (left != '0);
      assign rd_data[i*DATA_W +: DATA_W] = d;
   end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;
   localparam int DATA_W   = 32;
   localparam int NUM_RD   = 2;
   localparam int CNT_W    = 3;
   localparam int MAX_PEND = 5;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_RD*5-1:0]      rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     iss_valid, iss_hilo, iss_ready;
   logic [4:0]               iss_dst, wb_dst;
   logic                     wb_valid, hilo_valid, flush, err;
   logic [DATA_W-1:0]        wb_data, lo_data, hi_data;

   int total = 0;
   int bad   = 0;

   // Reference state: plain arrays of values and outstanding-write counts.
   logic [31:0] m_data [32];
   int          m_cnt  [32];
   bit          m_err;

   reg_file_scoreboard #(.DATA_W(DATA_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W), .MAX_PEND(MAX_PEND)) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_hilo(iss_hilo), .iss_ready(iss_ready),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
      .hilo_valid(hilo_valid), .lo_data(lo_data), .hi_data(hi_data),
      .flush(flush), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_conflict();
      return wb_valid && hilo_valid && (wb_dst >= 30);
   endfunction

   function automatic int m_dec(input int a);
      if (a == 0) return 0;
      if (hilo_valid && a >= 30) return 1;
      if (wb_valid && int'(wb_dst) == a && !m_conflict()) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] m_read(input int a);
      if (a == 0) return 0;
      if (hilo_valid && a == 30) return lo_data;
      if (hilo_valid && a == 31) return hi_data;
      if (wb_valid && int'(wb_dst) == a) return wb_data;
      return m_data[a];
   endfunction

   function automatic bit m_ready();
      bit r = 1;
      if (iss_valid && m_cnt[iss_dst] == MAX_PEND && m_dec(int'(iss_dst)) == 0) r = 0;
      if (iss_hilo) begin
         if (m_cnt[30] == MAX_PEND && m_dec(30) == 0) r = 0;
         if (m_cnt[31] == MAX_PEND && m_dec(31) == 0) r = 0;
      end
      return r;
   endfunction

   task automatic m_reset();
      for (int a = 0; a < 32; a++) begin
         m_data[a] = 0;
         m_cnt[a]  = 0;
      end
      m_err = 0;
   endtask

   task automatic idle();
      iss_valid = 0; iss_dst = 0; iss_hilo = 0;
      wb_valid = 0; wb_dst = 0; wb_data = 0;
      hilo_valid = 0; lo_data = 0; hi_data = 0;
      flush = 0;
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
   endtask

   // Let combinational outputs settle mid-cycle and compare against the model.
   task automatic settle();
      int a;
      #2;
      for (int i = 0; i < NUM_RD; i++) begin
         a = int'(rd_addr[i*5 +: 5]);
         chk($sformatf("rd_data%0d[r%0d]", i, a), rd_data[i*DATA_W +: DATA_W], m_read(a));
         chk($sformatf("rd_busy%0d[r%0d]", i, a), 32'(rd_busy[i]), 32'((m_cnt[a] - m_dec(a)) != 0));
      end
      chk("iss_ready", 32'(iss_ready), 32'(m_ready()));
      chk("err", 32'(err), 32'(m_err));
   endtask

   // Advance one clock, applying the architectural rules to the model.
   task automatic tick();
      logic [31:0] nd [32];
      int          nc [32];
      bit          ne, acc;
      int          inc, d, n;
      nd = m_data; nc = m_cnt; ne = m_err;
      acc = m_ready() && !flush;
      if (wb_valid && wb_dst != 0 && !m_conflict()) nd[wb_dst] = wb_data;
      if (hilo_valid) begin
         nd[30] = lo_data;
         nd[31] = hi_data;
      end
      if (m_conflict()) ne = 1;
      for (int a = 1; a < 32; a++) begin
         inc = (acc && ((iss_valid && int'(iss_dst) == a) || (iss_hilo && a >= 30))) ? 1 : 0;
         d   = m_dec(a);
         if (d == 1 && m_cnt[a] == 0) ne = 1;
         n = m_cnt[a] + inc - d;
         if (n < 0) n = 0;
         nc[a] = flush ? 0 : n;
      end
      @(posedge clk);
      #1;
      m_data = nd; m_cnt = nc; m_err = ne;
   endtask

   task automatic cycle();
      settle();
      tick();
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      m_reset();
   endtask

   function automatic logic [4:0] pick();
      case ($urandom_range(0, 6))
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd2;
         3: return 5'd29;
         4: return 5'd30;
         default: return 5'd31;
      endcase
   endfunction

   initial begin
      idle();
      set_rd(5'd5, 5'd0);
      m_reset();
      do_reset();

      // Reset state
      settle();
      chk("rst_rd0", rd_data[31:0], 32'h0);
      chk("rst_busy", 32'(rd_busy), 32'h0);
      chk("rst_ready", 32'(iss_ready), 32'h1);
      tick();

      // Mid-run asynchronous reset wipes data
      wb_valid = 1; wb_dst = 5; wb_data = 32'hDEAD;
      cycle();
      idle();
      settle();
      chk("r5_written", rd_data[31:0], 32'hDEAD);
      rst = 1;
      #1;
      m_reset();
      chk("async_rst_r5", rd_data[31:0], 32'h0);
      chk("async_rst_busy", 32'(rd_busy), 32'h0);
      chk("async_rst_err", 32'(err), 32'h0);
      @(posedge clk);
      #1;
      rst = 0;
      cycle();

      // Two reservations on r8 retire one at a time
      set_rd(5'd8, 5'd0);
      iss_valid = 1; iss_dst = 8;
      cycle(); cycle();
      idle();
      wb_valid = 1; wb_dst = 8; wb_data = 32'h11;
      settle();
      chk("r8_busy_after_1", 32'(rd_busy[0]), 32'h1);
      tick();
      wb_data = 32'h22;
      settle();
      chk("r8_busy_after_2", 32'(rd_busy[0]), 32'h0);
      tick();
      idle();
      settle();
      chk("r8_data", rd_data[31:0], 32'h22);
      tick();

      // Same-cycle write-through bypass
      set_rd(5'd0, 5'd3);
      wb_valid = 1; wb_dst = 3; wb_data = 32'hCAFE;
      settle();
      chk("r3_bypass", rd_data[63:32], 32'hCAFE);
      tick();
      idle();

      // r7 at MAX_PEND: stall, then issue+retire together holds the count
      set_rd(5'd7, 5'd0);
      iss_valid = 1; iss_dst = 7;
      for (int k = 0; k < MAX_PEND; k++) cycle();
      settle();
      chk("r7_full_stall", 32'(iss_ready), 32'h0);
      tick();
      wb_valid = 1; wb_dst = 7; wb_data = 32'h77;
      settle();
      chk("r7_issue_and_wb", 32'(iss_ready), 32'h1);
      tick();
      wb_valid = 0;
      settle();
      chk("r7_still_full", 32'(iss_ready), 32'h0);
      tick();
      idle();
      flush = 1;
      cycle();
      idle();

      // LO/HI reservation plus colliding general writeback
      set_rd(5'd30, 5'd31);
      iss_hilo = 1;
      cycle();
      idle();
      hilo_valid = 1; lo_data = 32'h1; hi_data = 32'h2;
      wb_valid = 1; wb_dst = 30; wb_data = 32'h99;
      cycle();
      idle();
      settle();
      chk("hilo_lo", rd_data[31:0], 32'h1);
      chk("hilo_hi", rd_data[63:32], 32'h2);
      chk("hilo_busy", 32'(rd_busy), 32'h0);
      chk("hilo_conflict_err", 32'(err), 32'h1);
      tick();

      // Flush, underflow, and writes to r0
      do_reset();
      set_rd(5'd4, 5'd9);
      iss_valid = 1; iss_dst = 4; cycle();
      iss_dst = 9; cycle();
      idle();
      flush = 1;
      cycle();
      idle();
      settle();
      chk("flush_busy", 32'(rd_busy), 32'h0);
      chk("flush_no_err", 32'(err), 32'h0);
      tick();
      wb_valid = 1; wb_dst = 4; wb_data = 32'h44;
      cycle();
      idle();
      settle();
      chk("underflow_data", rd_data[31:0], 32'h44);
      chk("underflow_err", 32'(err), 32'h1);
      tick();
      set_rd(5'd0, 5'd0);
      wb_valid = 1; wb_dst = 0; wb_data = 32'h55;
      settle();
      chk("r0_bypass", rd_data[31:0], 32'h0);
      tick();
      idle();
      settle();
      chk("r0_read", rd_data[63:32], 32'h0);
      tick();

      // Randomized traffic on a few registers against the model
      for (int blk = 0; blk < 6; blk++) begin
         do_reset();
         for (int c = 0; c < 100; c++) begin
            set_rd(pick(), pick());
            iss_valid  = ($urandom_range(0, 99) < 50);
            iss_dst    = pick();
            iss_hilo   = ($urandom_range(0, 99) < 15);
            wb_valid   = ($urandom_range(0, 99) < 40);
            wb_dst     = pick();
            wb_data    = $urandom;
            hilo_valid = ($urandom_range(0, 99) < 12);
            lo_data    = $urandom;
            hi_data    = $urandom;
            flush      = ($urandom_range(0, 99) < 3);
            cycle();
         end
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
